// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared defaults, state encoding and index-width helper for the UART TX arbiter
package uart_arb_pkg;
  localparam int NREQ_DEF = 4;
  localparam int MAX_BURST_DEF = 8;
  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin pick of the first set request at or after ptr
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N = NREQ_DEF,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % N);
      if (req[j]) idx = j;
    end
  end
  assign any = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter among NREQ byte requesters
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  localparam int IW = idx_w(NREQ),
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   gnt,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic [IW-1:0]     owner
);
  state_t state, state_nx;
  logic [IW-1:0] ptr, pick;
  logic [BW-1:0] cnt;
  logic any, accept, done;
  uart_rr_pick #(.N(NREQ)) u_pick (
    .req(req),
    .ptr(ptr),
    .idx(pick),
    .any(any)
  );
  assign accept = state == XFER && req[owner] && tx_ready;
  assign done = accept && (req_last[owner] || cnt == BW'(MAX_BURST - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == IDLE ? (any ? XFER : IDLE) : (!req[owner] || done ? IDLE : XFER);
  end
  always_comb begin
    busy = state == XFER;
    tx_valid = busy && req[owner];
    tx_data = req_data[{owner, 3'b000} +: 8];
    gnt = accept ? NREQ'(1) << owner : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      owner <= '0;
      cnt <= '0;
    end else begin
      if (state == IDLE && any) begin
        owner <= pick;
        cnt <= '0;
      end else if (accept) cnt <= cnt + 1'b1;
      if (state == XFER && state_nx == IDLE) ptr <= owner == IW'(NREQ - 1) ? '0 : owner + 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for the UART TX arbiter
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] req_last = '0;
  logic [31:0] req_data = '0;
  logic tx_ready = 1'b0;
  logic [3:0] gnt;
  logic tx_valid, busy;
  logic [7:0] tx_data;
  logic [1:0] owner;
  int n_chk = 0;
  int n_pass = 0;
  int n, cycles;
  always #5 clk = ~clk;
  uart_tx_arbiter #(.NREQ(4), .MAX_BURST(8)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .req_last(req_last),
    .gnt(gnt),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .busy(busy),
    .owner(owner)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_owner", owner, 0);
    rst = 1'b0;
    req = 4'b0001;
    req_last = 4'b0001;
    req_data[7:0] = 8'h55;
    tx_ready = 1'b1;
    #1;
    chk("t1_idle_valid", tx_valid, 0);
    cyc;
    chk("t1_valid", tx_valid, 1);
    chk("t1_data", tx_data, 8'h55);
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_owner", owner, 0);
    req = 4'b1001;
    req_last = 4'b1001;
    req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    cyc;
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_gnt", gnt, 0);
    chk("t1_idle_owner", owner, 0);
    cyc;
    chk("t1_ptr_owner", owner, 3);
    chk("t1_ptr_gnt", gnt, 4'b1000);
    chk("t1_ptr_data", tx_data, 8'hD3);
    req = 4'b1111;
    req_last = 4'b1111;
    cyc;
    chk("t1_end_busy", busy, 0);
    for (int k = 0; k < 5; k++) begin
      cyc;
      chk("t2_gnt", gnt, 32'(4'b0001 << (k % 4)));
      chk("t2_data", tx_data, 32'(8'hA0 + 8'h11 * (k % 4)));
      cyc;
      chk("t2_gap_busy", busy, 0);
      chk("t2_gap_gnt", gnt, 0);
    end
    req = 4'b0100;
    req_last = 4'b0000;
    req_data[23:16] = 8'h77;
    n = 0;
    cycles = 0;
    for (int i = 0; i < 12 && n < 8; i++) begin
      cyc;
      cycles++;
      if (gnt == 4'b0100) n++;
      else chk("t3_gnt_lane", gnt, 4'b0100);
    end
    chk("t3_pulses", n, 8);
    chk("t3_cycles", cycles, 8);
    chk("t3_busy_last", busy, 1);
    cyc;
    chk("t3_release", busy, 0);
    chk("t3_release_gnt", gnt, 0);
    req = 4'b1100;
    req_last = 4'b1000;
    req_data[31:24] = 8'h99;
    tx_ready = 1'b0;
    cyc;
    chk("t3_ptr_owner", owner, 3);
    for (int i = 0; i < 5; i++) begin
      chk("t4_valid", tx_valid, 1);
      chk("t4_data", tx_data, 8'h99);
      chk("t4_no_gnt", gnt, 0);
      cyc;
    end
    tx_ready = 1'b1;
    #1;
    chk("t4_gnt", gnt, 4'b1000);
    cyc;
    chk("t4_idle", busy, 0);
    req = 4'b0010;
    req_last = 4'b0000;
    tx_ready = 1'b0;
    req_data[15:8] = 8'h3C;
    cyc;
    chk("t5_busy", busy, 1);
    chk("t5_owner", owner, 1);
    req = 4'b0000;
    #1;
    chk("t5_drop_valid", tx_valid, 0);
    chk("t5_drop_gnt", gnt, 0);
    cyc;
    chk("t5_idle", busy, 0);
    chk("t5_idle_gnt", gnt, 0);
    req = 4'b0110;
    req_last = 4'b0100;
    tx_ready = 1'b1;
    cyc;
    chk("t5_ptr_owner", owner, 2);
    chk("t5_ptr_gnt", gnt, 4'b0100);
    req = 4'b0000;
    cyc;
    chk("t5_end", busy, 0);
    req = 4'b0010;
    req_last = 4'b0000;
    cyc;
    chk("t6_byte1", gnt, 4'b0010);
    cyc;
    chk("t6_byte2", gnt, 4'b0010);
    cyc;
    chk("t6_byte3", gnt, 4'b0010);
    chk("t6_data", tx_data, 8'h3C);
    rst = 1'b1;
    #1;
    chk("t6_rst_gnt", gnt, 0);
    chk("t6_rst_valid", tx_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_owner", owner, 0);
    cyc;
    rst = 1'b0;
    req = 4'b1010;
    cyc;
    chk("t6_after_owner", owner, 1);
    chk("t6_after_gnt", gnt, 4'b0010);
    req = 4'b0000;
    cyc;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
